// File: rtl/baudgen_rx_os_if.sv
// Interface between the UART RX FSM and the oversampling baud generator.
//   en          : frame-in-progress level from the FSM
//   rx_i        : raw RX pin
//   div_i       : divisor value (clocks per oversample tick)
//   div_load    : one-cycle load strobe for div_i
//   os_tick     : pulse once per oversample period
//   sample_tick : pulse at mid-bit; rx_bit is valid from this cycle
//   bit_tick    : pulse at end of each bit period
//   rx_bit      : sampled bit value
//   os_idx      : current oversample index
// master = FSM side, slave = baud generator side.
interface baudgen_rx_os_if #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned OS_W  = 4
);
  logic             en;
  logic             rx_i;
  logic [DIV_W-1:0] div_i;
  logic             div_load;
  logic             os_tick;
  logic             sample_tick;
  logic             bit_tick;
  logic             rx_bit;
  logic [OS_W-1:0]  os_idx;

  modport master (
    output en, rx_i, div_i, div_load,
    input  os_tick, sample_tick, bit_tick, rx_bit, os_idx
  );

  modport slave (
    input  en, rx_i, div_i, div_load,
    output os_tick, sample_tick, bit_tick, rx_bit, os_idx
  );
endinterface

// File: rtl/baudgen_rx_os.sv
// Oversampling UART receive timing generator.
// A prescaler divides clk by a runtime-programmable divisor to make
// OVERSAMPLE ticks per bit. From those ticks it derives a mid-bit sample
// strobe, a registered (optionally 2-of-3 voted) RX bit and an end-of-bit
// strobe. Timing is held cleared while en is low, so an en rise restarts
// the bit phase.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : baudgen_rx_os_if slave modport (en, rx_i, div_i, div_load in;
//           os_tick, sample_tick, bit_tick, rx_bit, os_idx out)
module baudgen_rx_os #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 68,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned MAJORITY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  baudgen_rx_os_if.slave        bus
);
  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned H    = OVERSAMPLE / 2;

  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] div_q, pend_q, pre_cnt, div_m1, div_clamp;
  logic             pend_v;
  logic [OS_W-1:0]  os_idx_q;
  logic             os_tick_q, sample_tick_q, bit_tick_q, rx_bit_q;
  logic             s0, s1;
  logic             wrap, idx_mid, idx_last, vote;

  always_comb begin
    div_m1    = div_q - DIV_W'(1);
    div_clamp = (bus.div_i == '0) ? DIV_W'(1) : bus.div_i;
    wrap      = bus.en && (pre_cnt == div_m1);
    idx_mid   = (os_idx_q == OS_W'(H - 1));
    idx_last  = (os_idx_q == OS_W'(OVERSAMPLE - 1));
    // third vote input is the live sample taken on the mid-bit edge itself
    vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  end

  // RX pin synchroniser, free-running regardless of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt       <= '0;
      os_idx_q      <= '0;
      os_tick_q     <= 1'b0;
      sample_tick_q <= 1'b0;
      bit_tick_q    <= 1'b0;
      rx_bit_q      <= 1'b1;
      s0            <= 1'b1;
      s1            <= 1'b1;
      div_q         <= DIV_W'(DEFAULT_DIV);
      pend_q        <= '0;
      pend_v        <= 1'b0;
    end else if (!bus.en) begin
      pre_cnt       <= '0;
      os_idx_q      <= '0;
      os_tick_q     <= 1'b0;
      sample_tick_q <= 1'b0;
      bit_tick_q    <= 1'b0;
      // a direct load is the most recent request, so it beats a stale pending value
      if (bus.div_load) begin
        div_q  <= div_clamp;
        pend_v <= 1'b0;
      end else if (pend_v) begin
        div_q  <= pend_q;
        pend_v <= 1'b0;
      end
    end else begin
      os_tick_q     <= wrap;
      sample_tick_q <= wrap && idx_mid;
      bit_tick_q    <= wrap && idx_last;
      if (wrap) begin
        pre_cnt  <= '0;
        os_idx_q <= idx_last ? '0 : os_idx_q + OS_W'(1);
        if (os_idx_q == OS_W'(H - 3)) s0 <= rx_s;
        if (os_idx_q == OS_W'(H - 2)) s1 <= rx_s;
        if (idx_mid) rx_bit_q <= (MAJORITY != 0) ? vote : rx_s;
      end else begin
        pre_cnt <= pre_cnt + DIV_W'(1);
      end
      // divisor changes only at a bit boundary; a load on that same edge
      // re-arms pending after the old pending value is applied
      if (wrap && idx_last && pend_v) begin
        div_q  <= pend_q;
        pend_v <= 1'b0;
      end
      if (bus.div_load) begin
        pend_q <= div_clamp;
        pend_v <= 1'b1;
      end
    end
  end

  assign bus.os_tick     = os_tick_q;
  assign bus.sample_tick = sample_tick_q;
  assign bus.bit_tick    = bit_tick_q;
  assign bus.rx_bit      = rx_bit_q;
  assign bus.os_idx      = os_idx_q;
endmodule

// File: tb/tb_baudgen_rx_os.sv
// Directed bench for baudgen_rx_os with OVERSAMPLE=8, DEFAULT_DIV=5.
// Two instances share stimulus: dut_a votes 2-of-3, dut_b takes a single sample.
module tb_baudgen_rx_os;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned OS_W  = 3;

  logic clk;
  logic rst_n;
  logic en, rx, div_load;
  logic [DIV_W-1:0] div_i;

  int n_checks = 0;
  int n_fail   = 0;

  baudgen_rx_os_if #(.DIV_W(DIV_W), .OS_W(OS_W)) ifa ();
  baudgen_rx_os_if #(.DIV_W(DIV_W), .OS_W(OS_W)) ifb ();

  assign ifa.en = en;  assign ifa.rx_i = rx;  assign ifa.div_i = div_i;  assign ifa.div_load = div_load;
  assign ifb.en = en;  assign ifb.rx_i = rx;  assign ifb.div_i = div_i;  assign ifb.div_load = div_load;

  baudgen_rx_os #(.DIV_W(DIV_W), .DEFAULT_DIV(5), .OVERSAMPLE(8), .MAJORITY(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  baudgen_rx_os #(.DIV_W(DIV_W), .DEFAULT_DIV(5), .OVERSAMPLE(8), .MAJORITY(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // {os_tick, sample_tick, bit_tick, os_idx[2:0], rx_bit}
  logic [6:0] obs_a, obs_b;
  assign obs_a = {ifa.os_tick, ifa.sample_tick, ifa.bit_tick, ifa.os_idx, ifa.rx_bit};
  assign obs_b = {ifb.os_tick, ifb.sample_tick, ifb.bit_tick, ifb.os_idx, ifb.rx_bit};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Expected outputs after en-high edge k. Divisor d1 up to edge sw (a bit
  // boundary), divisor d2 afterwards.
  function automatic logic [6:0] exp_vec(input int k, input int d1, input int sw,
                                         input int d2, input logic rxv);
    int dd, j, t;
    logic os, smp, bt;
    logic [2:0] idx;
    if (k <= sw) begin dd = d1; j = k; end
    else begin dd = d2; j = k - sw; end
    os  = (j % dd) == 0;
    t   = j / dd;
    idx = 3'(t % 8);
    smp = os && ((t % 8) == 4);
    bt  = os && ((t % 8) == 0);
    return {os, smp, bt, idx, rxv};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n, input logic ra, input logic rb);
    for (int i = 1; i <= n; i++) begin
      step();
      chk({tag, "_a"}, i, obs_a, {6'b000000, ra});
      chk({tag, "_b"}, i, obs_b, {6'b000000, rb});
    end
  endtask

  task automatic load_idle(input string tag, input logic [DIV_W-1:0] v, input logic ra, input logic rb);
    div_i    = v;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    chk({tag, "_a"}, 0, obs_a, {6'b000000, ra});
    chk({tag, "_b"}, 0, obs_b, {6'b000000, rb});
  endtask

  // Raise en and check n edges. glitch: rx_i low for that edge only (0 = none).
  // le/lv: div_load of lv on edge le (0 = none). pa/qa, pb/qb: rx_bit before/after first sample.
  task automatic frame(input string tag, input int n, input int d1, input int sw, input int d2,
                       input int glitch, input int le, input int lv,
                       input logic pa, input logic qa, input logic pb, input logic qb);
    en = 1'b1;
    for (int k = 1; k <= n; k++) begin
      if (glitch != 0) rx = (k == glitch) ? 1'b0 : 1'b1;
      if (k == le) begin
        div_i    = DIV_W'(lv);
        div_load = 1'b1;
      end
      step();
      div_load = 1'b0;
      chk({tag, "_a"}, k, obs_a, exp_vec(k, d1, sw, d2, (k < 4 * d1) ? pa : qa));
      chk({tag, "_b"}, k, obs_b, exp_vec(k, d1, sw, d2, (k < 4 * d1) ? pb : qb));
    end
  endtask

  task automatic drop(input string tag, input logic ra, input logic rb);
    en = 1'b0;
    idle(tag, 1, ra, rb);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; rx = 1'b0; div_i = '0; div_load = 1'b0;

    // reset holds everything cleared even with en high and rx low
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("reset_a", i, obs_a, 7'b000_000_1);
      chk("reset_b", i, obs_b, 7'b000_000_1);
    end
    en = 1'b0; rx = 1'b1; rst_n = 1'b1;
    load_idle("load4", 16'd4, 1'b1, 1'b1);
    idle("idle0", 2, 1'b1, 1'b1);

    // steady rx high; en drops on what would be a wrap edge (68)
    frame("steady", 67, 4, 1000, 4, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drop("drop_wrap", 1'b1, 1'b1);

    // rx low from 4 clk before edge 1
    rx = 1'b0;
    idle("pre0", 4, 1'b1, 1'b1);
    frame("rx0", 20, 4, 1000, 4, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    drop("drop_rx0", 1'b0, 1'b0);

    // rx_s low only at edge 12 (index H-2): both instances see 1
    rx = 1'b1;
    idle("pre1", 4, 1'b0, 1'b0);
    frame("glitch12", 20, 4, 1000, 4, 10, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    drop("drop_g12", 1'b1, 1'b1);

    // rx_s low only at edge 16 (index H-1): vote keeps 1, single sample takes 0
    frame("glitch16", 20, 4, 1000, 4, 14, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drop("drop_g16", 1'b1, 1'b0);

    // divisor 2 loaded mid-bit takes effect only after the bit_tick at edge 32
    frame("pendload", 50, 4, 32, 2, 0, 10, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    drop("drop_pend", 1'b1, 1'b1);

    // en dropped at edge 20 for 5 clk, then timing restarts from edge 1
    load_idle("load4b", 16'd4, 1'b1, 1'b1);
    frame("pre_drop", 19, 4, 1000, 4, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drop("drop20", 1'b1, 1'b1);
    idle("low", 4, 1'b1, 1'b1);
    frame("rerise", 20, 4, 1000, 4, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drop("drop_rr", 1'b1, 1'b1);

    // div_i=0 clamps to 1; a pending load of 4 is applied when en falls
    load_idle("load0", 16'd0, 1'b1, 1'b1);
    frame("div1", 5, 1, 1000, 1, 0, 3, 4, 1'b1, 1'b1, 1'b1, 1'b1);
    drop("drop_apply", 1'b1, 1'b1);

    // rx low frame with a pending load of 2, then reset at edge 18
    rx = 1'b0;
    idle("pre2", 4, 1'b1, 1'b1);
    frame("prerst", 17, 4, 1000, 4, 0, 10, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_imm_a", 0, obs_a, 7'b000_000_1);
    chk("rst_imm_b", 0, obs_b, 7'b000_000_1);
    idle("rst_hold", 2, 1'b1, 1'b1);
    en = 1'b0; rx = 1'b1; rst_n = 1'b1;
    idle("post_rst", 3, 1'b1, 1'b1);
    // default divisor 5, pending 2 discarded (would change spacing after edge 40)
    frame("defdiv", 50, 5, 1000, 5, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drop("drop_end", 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
